alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the single-cycle ALU; consumes the instruction word, 32-bit result and {ZF,SF,OF} flags it produces.
- Owns the architectural register file and drives the ALU's gr0/gr1 operand inputs from it, closing the loop.
- Performs register writeback, overflow trapping, beq/bne resolution and next-PC generation.
- Runs lw/sw through a req/ack memory port with a timeout counter.

Parameters:
- NUM_REGS, 2: number of architectural registers. Writes to index >= NUM_REGS are dropped.
- MEM_TIMEOUT, 15: maximum number of mem_req cycles without mem_ack before a bus-error exception.
- EXC_VECTOR, 32'h8000_0180: next_pc value on any exception.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction/result/flags/pc valid this cycle.
- in_ready  out  1  high only in IDLE; transfer occurs when in_valid && in_ready at a rising edge.
- i_datain  in  32  instruction word, same encoding the ALU decodes.
- pc  in  32  address of that instruction.
- result  in  32  ALU result.
- flags  in  3  ALU flags {ZF,SF,OF}.
- gr0  out  32  regs[0], combinational from the register array, to the ALU.
- gr1  out  32  regs[1], combinational from the register array, to the ALU.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- retire_valid  out  1  one-cycle pulse per accepted instruction.
- next_pc  out  32  valid with retire_valid.
- exc_code  out  2  valid with retire_valid: 00 none, 01 arithmetic overflow, 10 bus timeout.

Behaviour:
- Reset:
  - FSM goes to IDLE and all regs are cleared to 0.
  - mem_req, mem_we, retire_valid = 0; mem_addr, mem_wdata, next_pc = 0; exc_code = 00; timeout counter = 0.
  - Reset during MEM_RD/MEM_WR aborts the access: mem_req is low the cycle after the reset edge, no write, no retire.
- FSM states: IDLE, MEM_RD, MEM_WR.
- Decode fields: opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], func = [5:0], imm = [15:0]. simm = sign-extended imm.
- IDLE, accept edge, non-memory instruction: decode and update state in that same edge. Next cycle: retire_valid = 1 for exactly one cycle and in_ready = 1 again, so a back-to-back issue rate of 1 instruction/cycle is sustained.
  - opcode 0, func add(100000)/sub(100010) with OF=1: no write, exc_code=01, next_pc=EXC_VECTOR.
  - Other opcode 0 funcs (add/sub with OF=0, addu, subu, and, or, xor, nor, sll, srl, sra, sllv, srlv, srav): regs[rd] <= result.
  - opcode 0, func slt(101010)/sltu(101011): regs[rd] <= {31'b0, SF}.
  - addi(001000) with OF=1: trap as above. With OF=0: regs[rt] <= result.
  - addiu, andi, ori, xori: regs[rt] <= result.
  - slti, sltiu: regs[rt] <= {31'b0, SF}.
  - beq: taken iff ZF=1. bne: taken iff ZF=0. Taken: next_pc = pc + 4 + (simm << 2), mod 2^32. Not taken: next_pc = pc + 4.
  - Unknown opcode or func: no write, next_pc = pc + 4, exc_code = 00.
  - All non-trapping, non-branch cases: next_pc = pc + 4.
- lw/sw accept edge:
  - Capture rt and pc; mem_addr <= result; lw -> MEM_RD (mem_we=0), sw -> MEM_WR (mem_we=1, mem_wdata <= regs[rt], 0 if rt >= NUM_REGS).
  - mem_req = 1 from the next cycle; mem_addr, mem_we and mem_wdata are held stable while mem_req = 1.
- MEM state, counter increments each cycle mem_req is high:
  - mem_ack sampled high: lw writes regs[rt] <= mem_rdata; mem_req drops; next cycle retire with next_pc = pc + 4, exc_code 00; return to IDLE.
  - Counter reaches MEM_TIMEOUT with no ack: mem_req drops, no write; next cycle retire with exc_code 10, next_pc = EXC_VECTOR.
  - Ack arriving on the same edge the counter reaches MEM_TIMEOUT: ack wins.
- mem_ack while in IDLE is ignored. in_valid while in_ready = 0 is ignored; the upstream stage holds it.
- At most one regs write per edge. The written value is visible on gr0/gr1 in the following cycle.

Test Plan:
- Overflow trap: gr0=32'h7FFF_FFFF, gr1=1; i_datain=32'h0001_0820 (add rd=1), result=32'h8000_0000, flags=3'b001, pc=32'h40 -> gr1 stays 1; retire_valid one cycle, exc_code=01, next_pc=32'h8000_0180. Then addu 32'h0001_0821, flags=000 -> gr1=32'h8000_0000, exc_code=00, next_pc=32'h44.
- Branch: pc=32'h100, flags=3'b100; beq 32'h1001_FFFF -> next_pc=32'h100. bne 32'h1401_FFFF with same flags -> next_pc=32'h104. Check retire on consecutive cycles.
- Load: lw 32'h8C01_0004, result=32'h20; mem_ack after 3 req cycles with mem_rdata=32'hDEAD_BEEF -> mem_req high exactly 3 cycles, mem_addr=32'h20, mem_we=0, in_ready low throughout; gr1=32'hDEAD_BEEF; single retire.
- Store timeout: gr1=32'h1234_5678; sw 32'hAC01_0008, result=32'h10; no ack -> mem_req high 15 cycles, mem_wdata=32'h1234_5678, mem_we=1; then exc_code=10, next_pc=EXC_VECTOR, regs unchanged.
- slt and dropped write: 32'h0001_082A with flags=3'b010 -> gr1=1. 32'h0001_F820 (rd=31) -> no register changes, retire with next_pc=pc+4.
- Reset mid-load: assert rst in the 2nd mem_req cycle -> mem_req=0 next cycle, gr0=gr1=0, no retire_valid, in_ready=1 after reset releases.

Source files
------------

// File: rtl/alu_writeback_if.sv
// -----------------------------------------------------------------------------
// alu_writeback_if
//
// Bundles the three handshake groups of the ALU writeback stage:
//   * issue stream from the ALU : in_valid/in_ready, i_datain, pc, result, flags
//   * memory request port       : mem_req, mem_we, mem_addr, mem_wdata,
//                                 mem_rdata, mem_ack
//   * retire stream             : retire_valid, next_pc, exc_code
//
// Modports:
//   slave  - the writeback stage itself (consumes the issue stream, owns the
//            memory request and the retire stream).
//   master - its environment (ALU upstream, memory, retire consumer).
// -----------------------------------------------------------------------------
interface alu_writeback_if;

  // Issue stream from the ALU
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i_datain;
  logic [31:0] pc;
  logic [31:0] result;
  logic [2:0]  flags;      // {ZF, SF, OF}

  // Memory request port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Retire stream
  logic        retire_valid;
  logic [31:0] next_pc;
  logic [1:0]  exc_code;   // 00 none, 01 overflow, 10 bus timeout

  modport slave (
    input  in_valid, i_datain, pc, result, flags,
    input  mem_rdata, mem_ack,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output retire_valid, next_pc, exc_code
  );

  modport master (
    output in_valid, i_datain, pc, result, flags,
    output mem_rdata, mem_ack,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  retire_valid, next_pc, exc_code
  );

endinterface

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Stage directly behind the single-cycle ALU. It owns the architectural
// register file (and feeds regs[0]/regs[1] back to the ALU as gr0/gr1),
// performs register writeback, traps signed overflow, resolves beq/bne,
// generates next_pc, and runs lw/sw over a req/ack memory port guarded by a
// timeout counter.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous, active-high reset
//   bus   - alu_writeback_if.slave: issue stream, memory port, retire stream
//   gr0   - regs[0], combinational from the register array
//   gr1   - regs[1], combinational from the register array
//
// Parameters:
//   NUM_REGS    - architectural registers (>= 2); writes to higher indices
//                 are dropped, stores from them send 0
//   MEM_TIMEOUT - mem_req cycles without mem_ack before a bus-error exception
//   EXC_VECTOR  - next_pc reported with any exception
//
// Timing: a non-memory instruction is accepted and written back on one edge
// and retires in the following cycle, so one instruction per cycle is
// sustained. lw/sw hold in_ready low until the access completes or times out.
// -----------------------------------------------------------------------------
module alu_writeback #(
  parameter int          NUM_REGS    = 2,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180
) (
  input  logic           clk,
  input  logic           rst,
  alu_writeback_if.slave bus,
  output logic [31:0]    gr0,
  output logic [31:0]    gr1
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0]       NUM_REGS_L = 6'(NUM_REGS);
  localparam logic [CNT_W-1:0] TIMEOUT_L  = CNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEM_RD = 2'd1;
  localparam logic [1:0] MEM_WR = 2'd2;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_BUS  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [31:0]      regs [NUM_REGS];
  logic [4:0]       mem_rt;    // load destination captured at accept
  logic [31:0]      mem_pc;    // pc of the in-flight lw/sw
  logic [CNT_W-1:0] mem_cnt;   // mem_req cycles elapsed without ack

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        zf;
  logic        sf;
  logic        of;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic        accept;
  logic        is_mem;
  logic        is_load;

  assign opcode = bus.i_datain[31:26];
  assign rt     = bus.i_datain[20:16];
  assign rd     = bus.i_datain[15:11];
  assign func   = bus.i_datain[5:0];
  assign zf     = bus.flags[2];
  assign sf     = bus.flags[1];
  assign of     = bus.flags[0];

  // rs and shamt are consumed by the ALU only; folded here so they read as
  // intentionally ignored.
  logic unused_fields;
  assign unused_fields = ^{bus.i_datain[25:21], bus.i_datain[10:6]};

  assign seq_pc    = bus.pc + 32'd4;
  // simm << 2: sign bit replicated into the top 14 bits, two zero LSBs.
  assign br_target = seq_pc + {{14{bus.i_datain[15]}}, bus.i_datain[15:0], 2'b00};

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign is_load      = (opcode == OP_LW);
  assign is_mem       = is_load || (opcode == OP_SW);

  // Writeback / next-pc decision for a non-memory instruction.
  logic        dec_wr_en;
  logic [4:0]  dec_wr_idx;
  logic [31:0] dec_wr_data;
  logic [31:0] dec_npc;
  logic [1:0]  dec_exc;

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    dec_wr_en   = 1'b0;
    dec_wr_idx  = rt;
    dec_wr_data = bus.result;
    dec_npc     = seq_pc;
    dec_exc     = EXC_NONE;

    case (opcode)
      OP_RTYPE: begin
        dec_wr_idx = rd;
        case (func)
          F_ADD, F_SUB: begin
            if (of) begin
              dec_npc = EXC_VECTOR;
              dec_exc = EXC_OVF;
            end else begin
              dec_wr_en = 1'b1;
            end
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: dec_wr_en = 1'b1;
          F_SLT, F_SLTU: begin
            dec_wr_en   = 1'b1;
            dec_wr_data = {31'b0, sf};
          end
          default: ;  // unknown func: no write, fall through to pc + 4
        endcase
      end
      OP_ADDI: begin
        if (of) begin
          dec_npc = EXC_VECTOR;
          dec_exc = EXC_OVF;
        end else begin
          dec_wr_en = 1'b1;
        end
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: dec_wr_en = 1'b1;
      OP_SLTI, OP_SLTIU: begin
        dec_wr_en   = 1'b1;
        dec_wr_data = {31'b0, sf};
      end
      OP_BEQ: if (zf)  dec_npc = br_target;
      OP_BNE: if (!zf) dec_npc = br_target;
      default: ;  // unknown opcode (and lw/sw, handled by the FSM)
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: a single write port shared by ALU writeback and load data.
  // The two sources live in different states so they never collide.
  // ---------------------------------------------------------------------------
  logic        ld_done;
  logic        wr_en;
  logic        wr_hit;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [31:0] store_data;

  assign ld_done = (state == MEM_RD) && bus.mem_ack;
  assign wr_en   = ld_done || (accept && !is_mem && dec_wr_en);
  assign wr_idx  = ld_done ? mem_rt        : dec_wr_idx;
  assign wr_data = ld_done ? bus.mem_rdata : dec_wr_data;
  // Indices past the implemented file are silently dropped.
  assign wr_hit  = wr_en && ({1'b0, wr_idx} < NUM_REGS_L);

  assign store_data = ({1'b0, rt} < NUM_REGS_L) ? regs[rt[IDX_W-1:0]] : 32'd0;

  // NOTE: the register array is architecturally visible and must read as zero
  // after reset, so it is cleared here; a plain data buffer would not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  assign gr0 = regs[0];
  assign gr1 = regs[1];

  // ---------------------------------------------------------------------------
  // Control FSM, memory port and retire stream
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc     = mem_cnt + 1'b1;
  // mem_req is a pure state decode, so a reset during an access drops it in
  // the very next cycle.
  assign bus.mem_req = (state == MEM_RD) || (state == MEM_WR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mem_rt           <= '0;
      mem_pc           <= '0;
      mem_cnt          <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.retire_valid <= 1'b0;
      bus.next_pc      <= '0;
      bus.exc_code     <= EXC_NONE;
    end else begin
      bus.retire_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_mem) begin
              // Address/direction/data are latched once and then held for
              // the whole request.
              state        <= is_load ? MEM_RD : MEM_WR;
              mem_rt       <= rt;
              mem_pc       <= bus.pc;
              mem_cnt      <= '0;
              bus.mem_addr <= bus.result;
              bus.mem_we   <= !is_load;
              if (!is_load) bus.mem_wdata <= store_data;
            end else begin
              bus.retire_valid <= 1'b1;
              bus.next_pc      <= dec_npc;
              bus.exc_code     <= dec_exc;
            end
          end
        end

        MEM_RD, MEM_WR: begin
          // Ack is tested first so an ack on the final allowed cycle wins
          // over the timeout.
          if (bus.mem_ack) begin
            state            <= IDLE;
            bus.retire_valid <= 1'b1;
            bus.next_pc      <= mem_pc + 32'd4;
            bus.exc_code     <= EXC_NONE;
          end else if (cnt_inc == TIMEOUT_L) begin
            state            <= IDLE;
            bus.retire_valid <= 1'b1;
            bus.next_pc      <= EXC_VECTOR;
            bus.exc_code     <= EXC_BUS;
          end else begin
            mem_cnt <= cnt_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
//
// Directed bench for alu_writeback. A behavioural model tracks the
// architectural registers and the expected retire/memory behaviour from the
// instruction semantics; one compare process checks the DUT against it on
// every falling edge. Literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

  localparam int          NUM_REGS    = 2;
  localparam int          MEM_TIMEOUT = 15;
  localparam logic [31:0] EXC_VECTOR  = 32'h8000_0180;

  logic        clk;
  logic        rst;
  logic [31:0] gr0;
  logic [31:0] gr1;

  alu_writeback_if bus ();

  alu_writeback #(
    .NUM_REGS   (NUM_REGS),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .gr0(gr0),
    .gr1(gr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          we;
    int          idx;
    logic [31:0] data;
    logic [31:0] npc;
    logic [1:0]  exc;
  } eff_t;

  logic [31:0] m_regs [32];
  bit          model_valid = 1'b0;
  bit          m_busy;
  bit          m_load;
  int          m_rt;
  logic [31:0] m_pc;
  int          m_reqs;
  bit          exp_retire;
  logic [31:0] exp_npc;
  logic [1:0]  exp_exc;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  // Architectural effect of one non-memory instruction.
  function automatic eff_t exec(input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] res, input logic [2:0] fl);
    eff_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] seq;
    logic [31:0] tgt;
    op     = ins[31:26];
    fn     = ins[5:0];
    seq    = p + 32'd4;
    tgt    = seq + {{14{ins[15]}}, ins[15:0], 2'b00};
    e.we   = 1'b0;
    e.idx  = 0;
    e.data = res;
    e.npc  = seq;
    e.exc  = 2'b00;
    if (op == 6'd0) begin
      e.idx = int'(ins[15:11]);
      if ((fn == 6'h20 || fn == 6'h22) && fl[0]) begin
        e.npc = EXC_VECTOR;
        e.exc = 2'b01;
      end else if (fn == 6'h2A || fn == 6'h2B) begin
        e.we   = 1'b1;
        e.data = {31'b0, fl[1]};
      end else if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
        e.we = 1'b1;
      end
    end else begin
      e.idx = int'(ins[20:16]);
      case (op)
        6'h08: if (fl[0]) begin e.npc = EXC_VECTOR; e.exc = 2'b01; end
               else e.we = 1'b1;
        6'h09, 6'h0C, 6'h0D, 6'h0E: e.we = 1'b1;
        6'h0A, 6'h0B: begin e.we = 1'b1; e.data = {31'b0, fl[1]}; end
        6'h04: if (fl[2])  e.npc = tgt;
        6'h05: if (!fl[2]) e.npc = tgt;
        default: ;
      endcase
    end
    return e;
  endfunction

  // Advance one clock; update the model with what the DUT saw at that edge.
  task automatic cycle();
    eff_t       e;
    logic [5:0] op;
    @(posedge clk);
    #1;
    exp_retire = 1'b0;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_busy      = 1'b0;
      model_valid = 1'b1;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        op = bus.i_datain[31:26];
        if (op == 6'h23 || op == 6'h2B) begin
          m_busy   = 1'b1;
          m_load   = (op == 6'h23);
          m_rt     = int'(bus.i_datain[20:16]);
          m_pc     = bus.pc;
          m_reqs   = 0;
          exp_addr = bus.result;
          if (!m_load) exp_wdata = (m_rt < NUM_REGS) ? m_regs[m_rt] : 32'd0;
        end else begin
          e = exec(bus.i_datain, bus.pc, bus.result, bus.flags);
          if (e.we) m_regs[e.idx] = e.data;
          exp_retire = 1'b1;
          exp_npc    = e.npc;
          exp_exc    = e.exc;
        end
      end
    end else begin
      m_reqs++;
      if (bus.mem_ack) begin
        if (m_load) m_regs[m_rt] = bus.mem_rdata;
        m_busy     = 1'b0;
        exp_retire = 1'b1;
        exp_npc    = m_pc + 32'd4;
        exp_exc    = 2'b00;
      end else if (m_reqs == MEM_TIMEOUT) begin
        m_busy     = 1'b0;
        exp_retire = 1'b1;
        exp_npc    = EXC_VECTOR;
        exp_exc    = 2'b10;
      end
    end
  endtask

  // Compare process: regs with index >= NUM_REGS are never observable, and a
  // store reading them gets 0, which the model reflects at accept time.
  always @(negedge clk) begin
    if (model_valid) begin
      check("gr0", gr0, m_regs[0]);
      check("gr1", gr1, m_regs[1]);
      check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
      check("mem_req", 32'(bus.mem_req), 32'(m_busy));
      check("retire_valid", 32'(bus.retire_valid), 32'(exp_retire));
      if (exp_retire) begin
        check("next_pc", bus.next_pc, exp_npc);
        check("exc_code", 32'(bus.exc_code), 32'(exp_exc));
      end
      if (m_busy) begin
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_we", 32'(bus.mem_we), 32'(!m_load));
        if (!m_load) check("mem_wdata", bus.mem_wdata, exp_wdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] res, input logic [2:0] fl);
    bus.in_valid = 1'b1;
    bus.i_datain = ins;
    bus.pc       = p;
    bus.result   = res;
    bus.flags    = fl;
    cycle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int req_seen;
    bit done;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.i_datain  = '0;
    bus.pc        = '0;
    bus.result    = '0;
    bus.flags     = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    check("rst_retire", 32'(bus.retire_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_next_pc", bus.next_pc, 32'd0);
    check("rst_exc", 32'(bus.exc_code), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_gr1", gr1, 32'd0);

    // Overflow trap on add, then addu writes
    issue(32'h2400_FFFF, 32'h0, 32'h7FFF_FFFF, 3'b000);   // addiu r0
    issue(32'h2401_0001, 32'h4, 32'h0000_0001, 3'b000);   // addiu r1
    issue(32'h0001_0820, 32'h40, 32'h8000_0000, 3'b001);  // add r1, OF
    check("trap_retire", 32'(bus.retire_valid), 32'd1);
    check("trap_exc", 32'(bus.exc_code), 32'd1);
    check("trap_npc", bus.next_pc, 32'h8000_0180);
    check("trap_gr0", gr0, 32'h7FFF_FFFF);
    check("trap_gr1", gr1, 32'h0000_0001);
    issue(32'h0001_0821, 32'h40, 32'h8000_0000, 3'b000);  // addu r1
    check("addu_exc", 32'(bus.exc_code), 32'd0);
    check("addu_npc", bus.next_pc, 32'h0000_0044);
    check("addu_gr1", gr1, 32'h8000_0000);
    issue(32'h2001_0005, 32'h48, 32'h0000_0006, 3'b001);  // addi r1, OF
    check("addi_trap_exc", 32'(bus.exc_code), 32'd1);
    check("addi_trap_gr1", gr1, 32'h8000_0000);

    // Branches, back to back
    issue(32'h1001_FFFF, 32'h100, 32'h0, 3'b100);          // beq taken, -1
    check("beq_retire", 32'(bus.retire_valid), 32'd1);
    check("beq_npc", bus.next_pc, 32'h0000_0100);
    issue(32'h1401_FFFF, 32'h100, 32'h0, 3'b100);          // bne not taken
    check("bne_retire", 32'(bus.retire_valid), 32'd1);
    check("bne_npc", bus.next_pc, 32'h0000_0104);
    issue(32'h1401_0010, 32'h100, 32'h0, 3'b000);          // bne taken, +16
    check("bne_fwd_npc", bus.next_pc, 32'h0000_0144);
    issue(32'h1000_0008, 32'hFFFF_FFF0, 32'h0, 3'b100);    // beq wraps
    check("beq_wrap_npc", bus.next_pc, 32'h0000_0014);

    // slt/sltiu use SF, dropped write, unknown encodings
    issue(32'h0001_082A, 32'h200, 32'h0, 3'b010);          // slt r1
    check("slt_gr1", gr1, 32'h0000_0001);
    issue(32'h2C00_0000, 32'h204, 32'hFFFF_FFFF, 3'b000);  // sltiu r0
    check("sltiu_gr0", gr0, 32'h0000_0000);
    issue(32'h0001_F820, 32'h208, 32'h5555_5555, 3'b000);  // add r31
    check("drop_npc", bus.next_pc, 32'h0000_020C);
    check("drop_gr1", gr1, 32'h0000_0001);
    issue(32'hFC00_0000, 32'h20C, 32'h1, 3'b000);          // unknown opcode
    check("unk_op_npc", bus.next_pc, 32'h0000_0210);
    issue(32'h0001_083F, 32'h210, 32'h2, 3'b000);          // unknown func
    check("unk_fn_exc", 32'(bus.exc_code), 32'd0);
    bus.in_valid = 1'b0;
    cycle();

    // Load, ack in the 3rd request cycle; next instruction held upstream
    issue(32'h8C01_0004, 32'h300, 32'h0000_0020, 3'b000);
    issue(32'h2400_0BAD, 32'h304, 32'h0000_0BAD, 3'b000);  // ignored while busy
    req_seen = 1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k < 3; k++) begin
      if (bus.mem_req) req_seen++;
      if (k == 2) bus.mem_ack = 1'b1;
      cycle();
    end
    bus.mem_ack = 1'b0;
    check("lw_req_cycles", 32'(req_seen), 32'd3);
    check("lw_req_low", 32'(bus.mem_req), 32'd0);
    check("lw_addr", bus.mem_addr, 32'h0000_0020);
    check("lw_retire", 32'(bus.retire_valid), 32'd1);
    check("lw_npc", bus.next_pc, 32'h0000_0304);
    check("lw_gr1", gr1, 32'hDEAD_BEEF);
    cycle();                                               // held addiu now taken
    bus.in_valid = 1'b0;
    check("held_gr0", gr0, 32'h0000_0BAD);
    check("held_npc", bus.next_pc, 32'h0000_0308);

    // Load whose ack lands on the last allowed cycle: ack wins
    issue(32'h8C00_0000, 32'h400, 32'h0000_0044, 3'b000);
    bus.in_valid  = 1'b0;
    bus.mem_rdata = 32'hCAFE_F00D;
    req_seen = 0;
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      if (bus.mem_req) req_seen++;
      if (k == MEM_TIMEOUT - 1) bus.mem_ack = 1'b1;
      cycle();
    end
    bus.mem_ack = 1'b0;
    check("lw15_req_cycles", 32'(req_seen), 32'd15);
    check("lw15_exc", 32'(bus.exc_code), 32'd0);
    check("lw15_npc", bus.next_pc, 32'h0000_0404);
    check("lw15_gr0", gr0, 32'hCAFE_F00D);

    // Store timeout
    issue(32'h2401_5678, 32'h500, 32'h1234_5678, 3'b000);
    issue(32'hAC01_0008, 32'h504, 32'h0000_0010, 3'b000);
    bus.in_valid = 1'b0;
    req_seen = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.mem_req) req_seen++;
      cycle();
      if (bus.retire_valid) done = 1'b1;
    end
    check("sw_to_retired", 32'(done), 32'd1);
    check("sw_to_req_cycles", 32'(req_seen), 32'd15);
    check("sw_to_exc", 32'(bus.exc_code), 32'd2);
    check("sw_to_npc", bus.next_pc, 32'h8000_0180);
    check("sw_to_wdata", bus.mem_wdata, 32'h1234_5678);
    check("sw_to_gr1", gr1, 32'h1234_5678);

    // Store from an unimplemented register sends 0
    issue(32'hAC1F_0000, 32'h600, 32'h0000_0030, 3'b000);
    bus.in_valid = 1'b0;
    check("sw31_wdata", bus.mem_wdata, 32'd0);
    check("sw31_we", 32'(bus.mem_we), 32'd1);
    bus.mem_ack = 1'b1;
    cycle();
    bus.mem_ack = 1'b0;
    check("sw31_npc", bus.next_pc, 32'h0000_0604);

    // Stray ack while idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    cycle();
    bus.mem_ack = 1'b0;
    check("idle_ack_gr0", gr0, 32'hCAFE_F00D);

    // Reset in the 2nd request cycle of a load
    issue(32'h8C01_0004, 32'h700, 32'h0000_0024, 3'b000);
    bus.in_valid = 1'b0;
    cycle();
    check("rstld_req_before", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstld_req", 32'(bus.mem_req), 32'd0);
    check("rstld_retire", 32'(bus.retire_valid), 32'd0);
    check("rstld_gr0", gr0, 32'd0);
    check("rstld_gr1", gr1, 32'd0);
    cycle();
    check("rstld_in_ready", 32'(bus.in_ready), 32'd1);
    issue(32'h2401_0007, 32'h800, 32'h0000_0007, 3'b000);
    bus.in_valid = 1'b0;
    check("post_rst_gr1", gr1, 32'h0000_0007);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
